// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the instruction-immediate encoder: type codes, sizes,
// the FIFO entry layout and a sign-range helper.
package imm_encoder_pkg;

  typedef enum logic [2:0] {
    R_TYPE     = 3'd0,
    I_TYPE     = 3'd1,
    ISTAR_TYPE = 3'd2,
    S_TYPE     = 3'd3,
    B_TYPE     = 3'd4,
    U_TYPE     = 3'd5,
    J_TYPE     = 3'd6
  } imm_type_e;

  localparam int unsigned IMM_ENC_DEPTH = 2;
  localparam int unsigned ERR_CNT_W     = 8;

  typedef struct packed {
    logic        err;
    logic [31:0] inst;
  } enc_res_t;

  // True when v is the sign extension of its low w bits (w-bit two's complement range).
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
    logic [31:0] top;
    top = $signed(v) >>> (w - 1);
    return (top == '0) || (top == '1);
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bundle of the immediate encoder; slave is the encoder side,
// master is the producer/consumer side.
interface imm_encoder_if;
  import imm_encoder_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_base;
  logic [31:0]          in_imm;
  logic [2:0]           in_imm_type;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_inst;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_base, in_imm, in_imm_type, out_ready,
    input  in_ready, out_valid, out_inst, out_err, err_count
  );

  modport slave (
    input  in_valid, in_base, in_imm, in_imm_type, out_ready,
    output in_ready, out_valid, out_inst, out_err, err_count
  );

endinterface

// File: rtl/imm_encoder_comb.sv
// Combinational immediate scatter: clears the immediate fields of the template,
// ORs in the encoded bits and flags immediates that do not fit the format.
module imm_encode_comb
  import imm_encoder_pkg::*;
(
  input  logic [31:0] base_i,
  input  logic [31:0] imm_i,
  input  logic [2:0]  type_i,
  output logic [31:0] inst_o,
  output logic        err_o
);

  logic [31:0] field_mask;
  logic [31:0] field_bits;

  always_comb begin
    field_mask = '0;
    field_bits = '0;
    err_o      = 1'b0;
    case (type_i)
      R_TYPE: ;
      I_TYPE: begin
        field_mask = 32'hFFF0_0000;
        field_bits = {imm_i[11:0], 20'b0};
        err_o      = !fits_signed(imm_i, 12);
      end
      ISTAR_TYPE: begin
        // funct7 in [31:25] belongs to the template, only the shamt field is replaced
        field_mask = 32'h01F0_0000;
        field_bits = {7'b0, imm_i[4:0], 20'b0};
        err_o      = (imm_i[31:5] != '0);
      end
      S_TYPE: begin
        field_mask = 32'hFE00_0F80;
        field_bits = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
        err_o      = !fits_signed(imm_i, 12);
      end
      B_TYPE: begin
        field_mask = 32'hFE00_0F80;
        field_bits = {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
        err_o      = imm_i[0] || !fits_signed(imm_i, 13);
      end
      U_TYPE: begin
        field_mask = 32'hFFFF_F000;
        field_bits = {imm_i[31:12], 12'b0};
        err_o      = (imm_i[11:0] != '0);
      end
      J_TYPE: begin
        field_mask = 32'hFFFF_F000;
        field_bits = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0};
        err_o      = imm_i[0] || !fits_signed(imm_i, 21);
      end
      default: err_o = 1'b1;
    endcase
    inst_o = (base_i & ~field_mask) | field_bits;
  end

endmodule

// File: rtl/imm_encoder.sv
// Streaming immediate encoder: combinational encode into a 2-entry output FIFO
// plus a saturating count of accepted requests with unrepresentable immediates.
module imm_encoder
  import imm_encoder_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  imm_encoder_if.slave bus
);

  logic [31:0]          enc_inst;
  logic                 enc_err;
  logic                 push;
  logic                 pop;

  enc_res_t             mem_q [IMM_ENC_DEPTH];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  imm_encode_comb u_encode (
    .base_i (bus.in_base),
    .imm_i  (bus.in_imm),
    .type_i (bus.in_imm_type),
    .inst_o (enc_inst),
    .err_o  (enc_err)
  );

  // in_ready looks only at registered count, so a full FIFO refuses a push even when popping
  assign bus.in_ready  = (count_q != 2'(IMM_ENC_DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign bus.out_inst  = mem_q[rd_ptr_q].inst;
  assign bus.out_err   = mem_q[rd_ptr_q].err;
  assign bus.err_count = err_cnt_q;

  assign push = bus.in_valid  && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (push && enc_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= '0;
      err_cnt_q <= '0;
      for (int unsigned i = 0; i < IMM_ENC_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
      if (push) mem_q[wr_ptr_q] <= '{err: enc_err, inst: enc_inst};
    end
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Streaming instruction-immediate encoder: the inverse of the stage-1 immediate decode path. It accepts an instruction template plus a 32-bit immediate and an immediate type, range-checks the immediate, and scatters its bits into the RISC-V field positions. Results are buffered in a 2-entry output FIFO with valid/ready handshakes on both sides. The block sits in the test/boot-program assembly path that writes encoded instructions into IMEM, and it gives verification a round-trip check against the decoder.

## Interface
- No parameters. Depth is fixed at 2 entries; the error counter is fixed at 8 bits.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  an input request is present.
- `in_ready`  out  1  the encoder can accept a request.
- `in_base`  in  32  instruction template carrying opcode, rd, rs1, rs2 and funct fields.
- `in_imm`  in  32  immediate value, two's complement.
- `in_imm_type`  in  3  immediate type, using the stage-1 control-header encoding (`R_TYPE`, `I_TYPE`, `ISTAR_TYPE`, `S_TYPE`, `B_TYPE`, `U_TYPE`, `J_TYPE`).
- `out_valid`  out  1  the head FIFO entry is valid.
- `out_ready`  in  1  downstream accepts the head entry.
- `out_inst`  out  32  encoded instruction.
- `out_err`  out  1  the head entry's immediate was not representable.
- `err_count`  out  8  count of accepted erroneous requests; saturates at 255.

## Operation
- Accept occurs when `in_valid && in_ready`. Encoding is combinational on the input; the result {inst, err} is written to the FIFO tail on accept.
- Immediate field bits are first cleared from `in_base`, then the encoded immediate bits are ORed in. All other base bits pass through unchanged.
- Field placement and legality:
  - `I_TYPE`: imm[11:0] goes to bits [31:20]. Legal when -2048 ≤ imm ≤ 2047.
  - `ISTAR_TYPE`: imm[4:0] goes to bits [24:20]; bits [31:25] are kept from the base (funct7 for srai). Legal when 0 ≤ imm ≤ 31.
  - `S_TYPE`: imm[11:5] goes to [31:25] and imm[4:0] to [11:7]. Legal when -2048 ≤ imm ≤ 2047.
  - `B_TYPE`: imm[12] goes to [31], imm[10:5] to [30:25], imm[4:1] to [11:8], and imm[11] to [7]. Legal when imm[0]=0 and -4096 ≤ imm ≤ 4094.
  - `U_TYPE`: imm[31:12] goes to [31:12]. Legal when imm[11:0]=0.
  - `J_TYPE`: imm[20] goes to [31], imm[10:1] to [30:21], imm[11] to [20], and imm[19:12] to [19:12]. Legal when imm[0]=0 and -2^20 ≤ imm ≤ 2^20-2.
  - `R_TYPE`: the output is `in_base` unchanged and err=0.
  - Undefined type code: the output is `in_base` unchanged and err=1.
- Illegal immediates are still encoded using the truncated low bits, and err=1 is recorded.
- `err_count` increments by 1 on each accepted request with err=1, and holds at 255.
- FIFO state:
  - 2 entries, a `count` of 0..2, one read pointer and one write pointer.
  - `out_valid = (count != 0)`.
  - `in_ready = (count != 2)`, which depends on registered state only.
  - When full, there is no write even if a pop happens in the same cycle.
- Pop occurs when `out_valid && out_ready`. Push and pop in the same cycle leave `count` unchanged.
- Ordering is strictly first-in, first-out.

## Timing
- Reset values: `count`=0, both pointers=0, `out_valid`=0, `in_ready`=1, `err_count`=0, `out_inst`=0, `out_err`=0.
- Latency: a request accepted at edge N is visible on `out_*` after edge N with `out_valid`=1, which is 1 cycle.
- Throughput is 1 per cycle while `out_ready`=1.
- With `out_ready`=0, at most 2 requests are accepted; `in_ready` drops after the edge that fills the FIFO.
- `out_inst` and `out_err` are stable while `out_valid && !out_ready`.
- Asserting reset mid-operation discards all entries immediately (asynchronously) and clears `err_count`. The first accept is possible on the first edge after reset release.

## Structure
- The type codes come from the existing stage-1 control header and must not be redefined.
- A shared header adds `IMM_ENC_DEPTH`=2 and `ERR_CNT_W`=8.
- One sub-module, `imm_encode_comb`: a purely combinational function from (base, imm, type) to {inst, err}. The top level holds the FIFO and the counter.

## Test plan
- I-type, base 32'h0000_0013, imm 32'hFFFF_F800 -> `out_inst` 32'h8000_0013 and err=0 one cycle later.
- B-type, base 32'h0000_0063:
  - imm 8 -> 32'h0000_0463 with err=0.
  - imm 3 -> err=1 and `err_count`=1.
- J-type, base 32'h0000_006F, imm 32'hFFFF_FFFE -> 32'hFFFF_F06F.
- U-type, imm 32'h1234_5000, base 32'h37 -> 32'h1234_5037.
- ISTAR, imm 32 -> err=1.
- Backpressure:
  - Hold `out_ready`=0 and offer 3 requests -> `in_ready`=0 after the 2nd.
  - Release -> outputs arrive in order, with simultaneous push/pop sustained at count=1.
- Randomized round-trip: for each legal immediate, the decoder output of `out_inst` equals `in_imm`.
- 300 illegal requests -> `err_count` saturates at 255.
- Reset asserted with count=2 -> `out_valid`=0 and `err_count`=0 immediately.
